// File: rtl/vga_mon_pkg.sv
// vga_mon_pkg: shared types and constants for the VGA frame monitor.
// Holds the monitor FSM states, the 640x480 timing defaults and the counter width.
package vga_mon_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_TOTAL  = 525;

    localparam int CNT_W = 12;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Counters stick at full scale instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: normalises one sync input to active-high and flags its assertion edge,
// comparing only successive valid pixel samples.
module vga_sync_edge #(
    parameter bit ACT_LOW = 1'b1
) (
    input  logic clk,
    input  logic raw_reset,
    input  logic sample_vld,
    input  logic sync_raw,
    output logic edge_det
);

    logic sync_norm;
    logic prev_q;

    assign sync_norm = ACT_LOW ? ~sync_raw : sync_raw;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge raw_reset) begin
        if (!raw_reset) begin
            prev_q <= 1'b0;
        end else if (sample_vld) begin
            prev_q <= sync_norm;
        end
    end

    assign edge_det = sample_vld & sync_norm & ~prev_q;

endmodule

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: measures per-frame VGA timing and locks when it matches the parameters.
// Define VGA_MON_CHECKSUM_EN to include the active-pixel frame checksum (otherwise frame_sum is 0).
module vga_frame_monitor
    import vga_mon_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int SYNC_ACT_LOW = 1
) (
    input  logic             clk,
    input  logic             raw_reset,
    input  logic             pix_ce,
    input  logic [7:0]       VR,
    input  logic [7:0]       VG,
    input  logic [7:0]       VB,
    input  logic             blank_N,
    input  logic             H_Sync,
    input  logic             V_Sync,
    output logic             frame_valid,
    output logic [CNT_W-1:0] h_total_meas,
    output logic [CNT_W-1:0] h_active_meas,
    output logic [CNT_W-1:0] v_total_meas,
    output logic [CNT_W-1:0] v_active_meas,
    output logic [31:0]      frame_sum,
    output logic             timing_ok,
    output logic             locked,
    output logic [7:0]       err_cnt
);

    localparam logic [CNT_W-1:0] H_ACTIVE_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_TOTAL_C  = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] V_ACTIVE_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_TOTAL_C  = CNT_W'(V_TOTAL);
    localparam bit               ACT_LOW    = (SYNC_ACT_LOW != 0);

    mon_state_t state_q, state_n;

    logic blank_q, hs_q, vs_q, vld_q;
    logic h_edge, v_edge, timeout, frame_end, match;

    logic [CNT_W-1:0] h_cnt_q, h_cnt_n, h_act_q, h_act_n;
    logic [CNT_W-1:0] line_tot_q, line_tot_n, line_act_q, line_act_n;
    logic [CNT_W-1:0] v_tot_q, v_tot_n, v_act_q, v_act_n;

    // vld_q marks the clk on which the input stage holds a fresh sample.
    always_ff @(posedge clk or negedge raw_reset) begin
        if (!raw_reset) begin
            vld_q   <= 1'b0;
            blank_q <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            vld_q <= pix_ce;
            if (pix_ce) begin
                blank_q <= blank_N;
                hs_q    <= H_Sync;
                vs_q    <= V_Sync;
            end
        end
    end

    vga_sync_edge #(.ACT_LOW(ACT_LOW)) u_hs_edge (
        .clk        (clk),
        .raw_reset  (raw_reset),
        .sample_vld (vld_q),
        .sync_raw   (hs_q),
        .edge_det   (h_edge)
    );

    vga_sync_edge #(.ACT_LOW(ACT_LOW)) u_vs_edge (
        .clk        (clk),
        .raw_reset  (raw_reset),
        .sample_vld (vld_q),
        .sync_raw   (vs_q),
        .edge_det   (v_edge)
    );

    // An H edge closes the running line first, so a coincident V edge sees that line.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        h_cnt_n    = h_cnt_q;
        h_act_n    = h_act_q;
        line_tot_n = line_tot_q;
        line_act_n = line_act_q;
        v_tot_n    = v_tot_q;
        v_act_n    = v_act_q;
        if (vld_q) begin
            if (h_edge) begin
                line_tot_n = h_cnt_q;
                line_act_n = h_act_q;
                v_tot_n    = sat_inc(v_tot_q);
                if (h_act_q != '0) v_act_n = sat_inc(v_act_q);
                h_cnt_n    = CNT_W'(1);
                h_act_n    = CNT_W'(blank_q);
            end else begin
                h_cnt_n = sat_inc(h_cnt_q);
                if (blank_q) h_act_n = sat_inc(h_act_q);
            end
        end
    end

    assign match   = (line_tot_n == H_TOTAL_C) && (line_act_n == H_ACTIVE_C) &&
                     (v_tot_n == V_TOTAL_C) && (v_act_n == V_ACTIVE_C);
    assign timeout = vld_q && !h_edge && (h_cnt_q == CNT_MAX);

    always_comb begin
        state_n   = state_q;
        frame_end = 1'b0;
        if (timeout) begin
            state_n = SEARCH;
        end else if (v_edge) begin
            case (state_q)
                SEARCH:  state_n = MEASURE;
                MEASURE, LOCKED: begin
                    frame_end = 1'b1;
                    state_n   = match ? LOCKED : MEASURE;
                end
                default: state_n = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge raw_reset) begin
        if (!raw_reset) begin
            state_q       <= SEARCH;
            h_cnt_q       <= '0;
            h_act_q       <= '0;
            line_tot_q    <= '0;
            line_act_q    <= '0;
            v_tot_q       <= '0;
            v_act_q       <= '0;
            frame_valid   <= 1'b0;
            h_total_meas  <= '0;
            h_active_meas <= '0;
            v_total_meas  <= '0;
            v_active_meas <= '0;
            timing_ok     <= 1'b0;
            err_cnt       <= '0;
        end else begin
            state_q     <= state_n;
            frame_valid <= frame_end;
            h_cnt_q     <= h_cnt_n;
            h_act_q     <= h_act_n;
            line_tot_q  <= line_tot_n;
            line_act_q  <= line_act_n;
            if (v_edge || timeout) begin
                v_tot_q <= '0;
                v_act_q <= '0;
            end else begin
                v_tot_q <= v_tot_n;
                v_act_q <= v_act_n;
            end
            if (frame_end) begin
                h_total_meas  <= line_tot_n;
                h_active_meas <= line_act_n;
                v_total_meas  <= v_tot_n;
                v_active_meas <= v_act_n;
                timing_ok     <= match;
                if (!match && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
            if (timeout) timing_ok <= 1'b0;
        end
    end

    assign locked = (state_q == LOCKED);

`ifdef VGA_MON_CHECKSUM_EN
    logic [7:0]  vr_q, vg_q, vb_q;
    logic [9:0]  pix_sum;
    logic [31:0] sum_acc_q;

    assign pix_sum = 10'(vr_q) + 10'(vg_q) + 10'(vb_q);

    // The V-edge sample opens the new frame, mirroring how it opens a new line.
    always_ff @(posedge clk or negedge raw_reset) begin
        if (!raw_reset) begin
            vr_q      <= '0;
            vg_q      <= '0;
            vb_q      <= '0;
            sum_acc_q <= '0;
            frame_sum <= '0;
        end else begin
            if (pix_ce) begin
                vr_q <= VR;
                vg_q <= VG;
                vb_q <= VB;
            end
            if (frame_end) frame_sum <= sum_acc_q;
            if (timeout) begin
                sum_acc_q <= '0;
            end else if (v_edge) begin
                sum_acc_q <= blank_q ? 32'(pix_sum) : '0;
            end else if (vld_q && blank_q) begin
                sum_acc_q <= sum_acc_q + 32'(pix_sum);
            end
        end
    end
`else
    logic unused_colour;
    assign unused_colour = ^{VR, VG, VB};
    assign frame_sum     = '0;
`endif

endmodule
